seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier.sv | 138 +++++++++++++
 tb/tb_seq_multiplier.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one iteration per clock, fixed DW-cycle latency.
// Handshake: start accepted in IDLE, busy during RUN, done strobe in DONE.
// Optional feature: define SIGNED_MULT_EN for two's-complement operands with
// radix-2 Booth recoding; latency and handshake are identical in both builds.
module seq_multiplier #(
    parameter int unsigned DW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [DW-1:0]   multiplicand,
    input  logic [DW-1:0]   multiplier,
    output logic [2*DW-1:0] product,
    output logic            busy,
    output logic            done
);

    localparam int unsigned CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   a_q, a_d;
    // Upper half is the running partial product (cleared on accept); the lower
    // half holds the not-yet-consumed multiplier bits, LSB first.
    logic [2*DW-1:0] acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*DW-1:0] prod_q, prod_d;
    logic            busy_q, done_q;
    logic [DW:0]     sum;
    logic [2*DW-1:0] acc_step;
`ifdef SIGNED_MULT_EN
    // Booth needs the multiplier bit shifted out on the previous iteration.
    logic            prev_q, prev_d;
    logic [DW:0]     hi_ext;
    logic [DW:0]     a_ext;
`else
    logic [DW-1:0]   addend;
`endif

    // One multiply iteration: add into the upper half with a DW+1 bit adder, then shift right.
    always_comb begin
`ifdef SIGNED_MULT_EN
        hi_ext = {acc_q[2*DW-1], acc_q[2*DW-1:DW]};
        a_ext  = {a_q[DW-1], a_q};
        case ({acc_q[0], prev_q})
            2'b01:   sum = hi_ext + a_ext;
            2'b10:   sum = hi_ext - a_ext;
            default: sum = hi_ext;
        endcase
`else
        addend = acc_q[0] ? a_q : '0;
        sum    = {1'b0, acc_q[2*DW-1:DW]} + {1'b0, addend};
`endif
        // Keeping the ninth bit as the new MSB preserves the carry (unsigned)
        // or the sign (signed), making this an arithmetic shift in Booth mode.
        acc_step = {sum, acc_q[DW-1:1]};
    end

    // Next-state logic for the IDLE/RUN/DONE controller and datapath registers.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
`ifdef SIGNED_MULT_EN
        prev_d  = prev_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    a_d     = multiplicand;
                    acc_d   = {{DW{1'b0}}, multiplier};
                    cnt_d   = CW'(DW);
`ifdef SIGNED_MULT_EN
                    prev_d  = 1'b0;
`endif
                end
            end
            StRun: begin
                acc_d = acc_step;
                cnt_d = cnt_q - CW'(1);
`ifdef SIGNED_MULT_EN
                prev_d = acc_q[0];
`endif
                // Last iteration: publish the result on the same edge it is formed.
                if (cnt_q == CW'(1)) begin
                    state_d = StDone;
                    prod_d  = acc_step;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; status flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SIGNED_MULT_EN
            prev_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            busy_q  <= (state_d == StRun);
            done_q  <= (state_d == StDone);
`ifdef SIGNED_MULT_EN
            prev_q  <= prev_d;
`endif
        end
    end

    assign product = prod_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (DW=8): directed vector table,
// hand-written protocol sequences and randomized operands against a plain
// arithmetic reference. Honours SIGNED_MULT_EN the same way as the design.
module tb_seq_multiplier;

    localparam int unsigned DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [DW-1:0]   multiplicand;
    logic [DW-1:0]   multiplier;
    logic [2*DW-1:0] product;
    logic            busy;
    logic            done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    seq_multiplier #(.DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .product     (product),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
        logic [2*DW-1:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: widen both operands to 2*DW (sign- or zero-extended) and multiply;
    // the low 2*DW bits are the exact product in either number system.
    function automatic logic [2*DW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [2*DW-1:0] ea, eb;
`ifdef SIGNED_MULT_EN
        ea = {{DW{a[DW-1]}}, a};
        eb = {{DW{b[DW-1]}}, b};
`else
        ea = {{DW{1'b0}}, a};
        eb = {{DW{1'b0}}, b};
`endif
        return ea * eb;
    endfunction

    // Issue one operation, scramble the operands after acceptance, and wait
    // (bounded) for done. lat counts edges from acceptance to the done sample.
    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          output logic [2*DW-1:0] got, output int lat,
                          output int busy_cnt, output logic hold_ok);
        logic [2*DW-1:0] prev;
        prev         = product;
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        multiplicand = DW'($urandom);
        multiplier   = DW'($urandom);
        hold_ok      = 1'b1;
        busy_cnt     = busy ? 1 : 0;
        lat          = 0;
        if (product !== prev) hold_ok = 1'b0;
        while (lat < 20) begin
            tick();
            lat++;
            if (done) break;
            if (busy) busy_cnt++;
            if (product !== prev) hold_ok = 1'b0;
        end
        got = product;
    endtask

    initial begin
        logic [2*DW-1:0] got, p0, p1, prev;
        logic [DW-1:0]   ra, rb;
        logic            hold_ok;
        int              lat, bcnt, ndone, c0, c1;

`ifdef SIGNED_MULT_EN
        vecs[0] = '{8'h80, 8'h80, 16'h4000};
        vecs[1] = '{8'hFF, 8'h7F, 16'hFF81};
        vecs[2] = '{8'hFD, 8'h05, 16'hFFF1};
        vecs[3] = '{8'h00, 8'hAD, 16'h0000};
        vecs[4] = '{8'h7F, 8'h7F, 16'h3F01};
        vecs[5] = '{8'h80, 8'h7F, 16'hC080};
`else
        vecs[0] = '{8'hFF, 8'hFF, 16'hFE01};
        vecs[1] = '{8'h00, 8'hAD, 16'h0000};
        vecs[2] = '{8'h01, 8'hAD, 16'h00AD};
        vecs[3] = '{8'h80, 8'h02, 16'h0100};
        vecs[4] = '{8'hAD, 8'h00, 16'h0000};
        vecs[5] = '{8'h10, 8'h10, 16'h0100};
`endif

        reset = 1'b1;
        start = 1'b1;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) tick();
        check("reset_product", 32'(product), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        start = 1'b0;
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'h0);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, got, lat, bcnt, hold_ok);
            check($sformatf("vec%0d_product", i), 32'(got), 32'(vecs[i].exp));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
            check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd8);
            check($sformatf("vec%0d_hold", i), 32'(hold_ok), 32'h1);
            tick();
            check($sformatf("vec%0d_done_fall", i), 32'(done), 32'h0);
        end

        // Extra start and operand change during RUN: exactly one result, 3*5
        prev = product;
        multiplicand = 8'd3;
        multiplier   = 8'd5;
        start = 1'b1;
        tick();
        multiplicand = 8'd7;
        multiplier   = 8'd9;
        tick();
        start = 1'b0;
        ndone = 0;
        hold_ok = 1'b1;
        got = '0;
        for (int i = 0; i < 14; i++) begin
            if (done) begin
                ndone++;
                got = product;
            end else if (busy && product !== prev) begin
                hold_ok = 1'b0;
            end
            tick();
        end
        check("proto_done_count", 32'(ndone), 32'd1);
        check("proto_product", 32'(got), 32'h000F);
        check("proto_hold", 32'(hold_ok), 32'h1);

        // Reset four cycles into RUN
        multiplicand = 8'd9;
        multiplier   = 8'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("midrst_busy_before", 32'(busy), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_done", 32'(done), 32'h0);
        check("midrst_product", 32'(product), 32'h0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) ndone++;
            tick();
        end
        check("midrst_no_done", 32'(ndone), 32'd0);
        run_op(8'd12, 8'd10, got, lat, bcnt, hold_ok);
        check("midrst_next_product", 32'(got), 32'h0078);
        check("midrst_next_latency", 32'(lat), 32'd8);
        tick();

        // Back-to-back with start held high
        multiplicand = 8'd2;
        multiplier   = 8'd3;
        start = 1'b1;
        tick();
        multiplicand = 8'd4;
        multiplier   = 8'd5;
        ndone = 0;
        c0 = 0;
        c1 = 0;
        p0 = '0;
        p1 = '0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                if (ndone == 0) begin
                    c0 = cyc;
                    p0 = product;
                end else if (ndone == 1) begin
                    c1 = cyc;
                    p1 = product;
                    start = 1'b0;
                end
                ndone++;
            end
            tick();
        end
        start = 1'b0;
        check("b2b_done_count", 32'(ndone), 32'd2);
        check("b2b_spacing", 32'(c1 - c0), 32'd10);
        check("b2b_product0", 32'(p0), 32'(ref_mul(8'd2, 8'd3)));
        check("b2b_product1", 32'(p1), 32'(ref_mul(8'd4, 8'd5)));

        // Randomized operands against the reference
        for (int i = 0; i < 150; i++) begin
            ra = DW'($urandom);
            rb = DW'($urandom);
            if (i == 0) ra = '1;
            if (i == 1) rb = '1;
            run_op(ra, rb, got, lat, bcnt, hold_ok);
            check($sformatf("rand%0d_%0h_%0h", i, ra, rb), 32'(got), 32'(ref_mul(ra, rb)));
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'd8);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
